hilo_muldiv: RTL and testbench
==============================

# hilo_muldiv

Iterative multiply/divide unit owning the HI/LO register pair for the MIPS core, parametrised in operand width. It sits beside the ALU in the execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests decoded from the R-type funct field. It holds `busy` while a multi-cycle operation runs; the core stalls on `busy` and reads HI/LO through its existing register-file write-data mux (MFHI/MFLO).

## Interface
- `WIDTH`, 32: operand and HI/LO width. Must be ≥ 4 and even.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request valid this cycle; sampled only when `busy`=0.
- `flush` in 1: abort any in-flight operation (exception/branch squash).
- `funct` in 6: R-type funct code of the request.
- `a` in WIDTH: rs operand (dividend / multiplicand / MT* source).
- `b` in WIDTH: rt operand (divisor / multiplier).
- `busy` out 1: multi-cycle operation in progress.
- `done` out 1: one-cycle pulse; HI/LO hold the new result this cycle.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- Funct codes:
  - MULT 011000
  - MULTU 011001
  - DIV 011010
  - DIVU 011011
  - MTHI 010001
  - MTLO 010011
- Any other funct with `start`=1 is ignored: no state change, no `busy`.
- States:
  - IDLE → RUN on `start`·mul/div·!`flush`.
  - RUN → FIX after WIDTH iterations.
  - FIX → IDLE unconditionally.
  - `flush` in RUN or FIX → IDLE.
- MTHI/MTLO: `hi`/`lo` ← `a` at the accepting edge. They are single-cycle, with no `busy` and no `done`.
- Capture at the accepting edge:
  - Signed ops (MULT, DIV) store |a|, |b| and record the two sign bits.
  - Unsigned ops store `a`, `b` unchanged.
  - Iteration counter ← 0.
- RUN, multiply: radix-2 shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- RUN, divide: restoring division, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
- FIX:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
  - {`hi`,`lo`} ← product; `lo` ← quotient, `hi` ← remainder.
- Divide by zero, signed or unsigned: `lo` = all ones, `hi` = `a` as captured (original signed value). No trap.
- Signed min ÷ −1: `lo` = min, `hi` = 0. This falls out of the magnitude algorithm.
- `flush`: returns to IDLE. `hi`/`lo` keep their pre-operation values, and `done` is not pulsed.
- `start` while `busy`=1 is ignored; upstream holds the instruction stalled.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- Accept at edge E0. `busy`=1 from E0 through edge E0+WIDTH+1 (WIDTH+1 cycles).
- `hi`/`lo` update at edge E0+WIDTH+1. In the cycle after that edge, `done`=1 and `busy`=0.
- A new `start` is accepted in that same cycle (back-to-back).
- `busy` is registered; it never depends combinationally on `start`.
- `flush` and `start` in the same IDLE cycle: `flush` wins; the request is dropped, including MT*.
- `rst` mid-operation: everything returns to reset values at the next edge.

## Configuration
- `HILO_MULDIV_DIV_EN`:
  - Defined: DIV/DIVU are supported as above.
  - Undefined: the divider datapath is not built, and DIV/DIVU are treated as unknown funct (ignored, no `busy`, HI/LO unchanged). Multiply and MT* behaviour is identical.

## Structure
- Package `hilo_muldiv_pkg` holds:
  - The funct code localparams.
  - The state enum (IDLE, RUN, FIX).
  - The op-kind enum (MUL, DIV).
- Sub-module `muldiv_step`: combinational one-iteration datapath. It takes accumulator/remainder, operand and op kind, and returns the next accumulator/remainder. The top holds the FSM, counter, sign flags and HI/LO registers.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF (WIDTH=32) → `busy` for 33 cycles, `done` pulse; `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULT a=−3 (0xFFFFFFFD), b=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Then MTHI a=0x1234 → `hi`=0x1234 next cycle, no `busy`.
- DIV a=−7, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then DIVU a=100, b=0 → `lo`=0xFFFFFFFF, `hi`=100.
- DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MULTU started with `hi`=5, `lo`=6; assert `flush` at cycle 10 → `busy` drops next cycle, no `done`, `hi`=5, `lo`=6. Assert `rst` mid-op → `hi`=`lo`=0.
- Back-to-back: second `start` in the `done` cycle is accepted, with correct results for both. `start` with funct=100000 → ignored. Build without `HILO_MULDIV_DIV_EN`: DIVU → ignored.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: funct codes, FSM states, op kinds.
package hilo_muldiv_pkg;

  localparam logic [5:0] FunctMthi  = 6'b010001;
  localparam logic [5:0] FunctMtlo  = 6'b010011;
  localparam logic [5:0] FunctMult  = 6'b011000;
  localparam logic [5:0] FunctMultu = 6'b011001;
  localparam logic [5:0] FunctDiv   = 6'b011010;
  localparam logic [5:0] FunctDivu  = 6'b011011;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  typedef enum logic {
    OpMul = 1'b0,
    OpDiv = 1'b1
  } op_kind_e;

endpackage

// File: rtl/hilo_muldiv_step.sv
// One iteration of the shift-add multiplier or restoring divider (combinational).
// The divide path and its ports exist only when HILO_MULDIV_DIV_EN is defined.
module muldiv_step
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
`ifdef HILO_MULDIV_DIV_EN
  input  op_kind_e           op,
  input  logic [WIDTH:0]     rem,
  output logic [WIDTH:0]     rem_next,
`endif
  input  logic [WIDTH-1:0]   operand,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_next;

  // Multiplier bits leave from acc[0]; the partial product enters from the top.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    mul_next = {sum, acc[WIDTH-1:1]};
  end

`ifdef HILO_MULDIV_DIV_EN
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  // acc[WIDTH-1:0] shifts the dividend out at the top and the quotient in at the bottom.
  always_comb begin
    shifted  = {rem, acc[WIDTH-1]};
    diff     = shifted - {2'b00, operand};
    borrow   = diff[WIDTH+1];
    acc_next = mul_next;
    rem_next = rem;
    if (op == OpDiv) begin
      acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~borrow};
      rem_next = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
    end
  end
`else
  assign acc_next = mul_next;
`endif

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit owning HI/LO. Divide support is built only when
// HILO_MULDIV_DIV_EN is defined; otherwise DIV/DIVU are ignored like unknown functs.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned     CntW     = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_next;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_res_q, neg_res_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_mul, is_div, signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;

`ifdef HILO_MULDIV_DIV_EN
  logic [WIDTH:0]     rem_q, rem_d, rem_next;
  op_kind_e           op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               div_zero_q, div_zero_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   quo, rmd;

  assign is_div    = (funct == FunctDiv) || (funct == FunctDivu);
  assign signed_op = (funct == FunctMult) || (funct == FunctDiv);
  assign quo       = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rmd       = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
`else
  assign is_div    = 1'b0;
  assign signed_op = (funct == FunctMult);
`endif

  assign is_mul = (funct == FunctMult) || (funct == FunctMultu);
  assign a_mag  = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (signed_op && b[WIDTH-1]) ? -b : b;
  assign prod   = neg_res_q ? -acc_q : acc_q;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
`ifdef HILO_MULDIV_DIV_EN
    .op      (op_q),
    .rem     (rem_q),
    .rem_next(rem_next),
`endif
    .operand (opnd_q),
    .acc     (acc_q),
    .acc_next(acc_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
`ifdef HILO_MULDIV_DIV_EN
    rem_d      = rem_q;
    op_d       = op_q;
    a_d        = a_q;
    div_zero_d = div_zero_q;
    neg_rem_d  = neg_rem_q;
`endif
    case (state_q)
      StIdle: begin
        if (start && !flush) begin
          if (funct == FunctMthi) hi_d = a;
          if (funct == FunctMtlo) lo_d = a;
          if (is_mul || is_div) begin
            state_d   = StRun;
            cnt_d     = '0;
            // Multiply iterates over b; divide shifts a (the dividend) through acc.
            acc_d     = {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
            opnd_d    = is_div ? b_mag : a_mag;
            neg_res_d = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef HILO_MULDIV_DIV_EN
            rem_d      = '0;
            op_d       = is_div ? OpDiv : OpMul;
            a_d        = a;
            div_zero_d = (b == '0);
            neg_rem_d  = signed_op && a[WIDTH-1];
`endif
          end
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = acc_next;
`ifdef HILO_MULDIV_DIV_EN
          rem_d = rem_next;
`endif
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastIter) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          done_d       = 1'b1;
          {hi_d, lo_d} = prod;
`ifdef HILO_MULDIV_DIV_EN
          if (op_q == OpDiv) begin
            lo_d = div_zero_q ? '1 : quo;
            hi_d = div_zero_q ? a_q : rmd;
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
`ifdef HILO_MULDIV_DIV_EN
      rem_q      <= '0;
      op_q       <= OpMul;
      a_q        <= '0;
      div_zero_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
`ifdef HILO_MULDIV_DIV_EN
      rem_q      <= rem_d;
      op_q       <= op_d;
      a_q        <= a_d;
      div_zero_q <= div_zero_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed cases plus random ops against an
// arithmetic reference model of HI/LO.
module tb_hilo_muldiv;

  localparam int unsigned W = 32;

  localparam logic [5:0] FMthi  = 6'b010001;
  localparam logic [5:0] FMtlo  = 6'b010011;
  localparam logic [5:0] FMult  = 6'b011000;
  localparam logic [5:0] FMultu = 6'b011001;
  localparam logic [5:0] FDiv   = 6'b011010;
  localparam logic [5:0] FDivu  = 6'b011011;

`ifdef HILO_MULDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [5:0]   funct;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  hilo_muldiv #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .flush(flush),
    .funct(funct),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_multi(input logic [5:0] f);
    return (f == FMult) || (f == FMultu) || (DivEn && ((f == FDiv) || (f == FDivu)));
  endfunction

  // Architectural effect of a completed request on HI/LO.
  task automatic model(input logic [5:0] f, input logic [31:0] ma, input logic [31:0] mb);
    longint      la, lb;
    logic [63:0] p;
    int          sa, sb;
    la = longint'($signed(ma));
    lb = longint'($signed(mb));
    sa = ma;
    sb = mb;
    case (f)
      FMthi: exp_hi = ma;
      FMtlo: exp_lo = ma;
      FMult: begin
        p = la * lb;
        {exp_hi, exp_lo} = p;
      end
      FMultu: begin
        p = {32'd0, ma} * {32'd0, mb};
        {exp_hi, exp_lo} = p;
      end
      FDiv: if (DivEn) begin
        if (mb == 0) begin
          exp_lo = '1;
          exp_hi = ma;
        end else if (ma == 32'h8000_0000 && mb == 32'hffff_ffff) begin
          exp_lo = ma;
          exp_hi = '0;
        end else begin
          exp_lo = sa / sb;
          exp_hi = sa % sb;
        end
      end
      FDivu: if (DivEn) begin
        if (mb == 0) begin
          exp_lo = '1;
          exp_hi = ma;
        end else begin
          exp_lo = ma / mb;
          exp_hi = ma % mb;
        end
      end
      default: ;
    endcase
  endtask

  // Entered and left at a negedge; leaves in the done cycle so the next call is back-to-back.
  task automatic run_op(input logic [5:0] f, input logic [31:0] oa, input logic [31:0] ob,
                        input bit poke);
    int cyc;
    start = 1'b1;
    funct = f;
    a     = oa;
    b     = ob;
    model(f, oa, ob);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    if (is_multi(f)) begin
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
        if (poke && cyc == 5) begin
          start = 1'b1;
          funct = FMthi;
          a     = 32'hdead_beef;
        end else begin
          start = 1'b0;
        end
        cyc++;
        @(negedge clk);
      end
      start = 1'b0;
      chk("busy_cycles", 64'(cyc), 64'(W + 1));
      chk("done_pulse", 64'(done), 64'd1);
    end else begin
      chk("no_busy", 64'(busy), 64'd0);
      chk("no_done", 64'(done), 64'd0);
    end
    chk("hi", 64'(hi), 64'(exp_hi));
    chk("lo", 64'(lo), 64'(exp_lo));
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [6];
    specials[0] = 32'h0000_0000;
    specials[1] = 32'hffff_ffff;
    specials[2] = 32'h8000_0000;
    specials[3] = 32'h7fff_ffff;
    specials[4] = 32'h0000_0001;
    specials[5] = 32'h0000_0002;
    if ($urandom_range(3) == 0) return specials[$urandom_range(5)];
    if ($urandom_range(1) == 0) return $urandom_range(1000);
    return $urandom;
  endfunction

  initial begin
    logic [5:0] ops [8];
    ops[0] = FMult;
    ops[1] = FMultu;
    ops[2] = FDiv;
    ops[3] = FDivu;
    ops[4] = FMthi;
    ops[5] = FMtlo;
    ops[6] = 6'b100000;
    ops[7] = 6'b000000;

    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    funct = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);

    run_op(FMultu, 32'hffff_ffff, 32'hffff_ffff, 1'b0);
    chk("multu_max_hi", 64'(hi), 64'h0000_0000_ffff_fffe);
    chk("multu_max_lo", 64'(lo), 64'h0000_0000_0000_0001);
    run_op(FMult, 32'hffff_fffd, 32'd7, 1'b0);
    chk("mult_neg_hi", 64'(hi), 64'h0000_0000_ffff_ffff);
    chk("mult_neg_lo", 64'(lo), 64'h0000_0000_ffff_ffeb);
    run_op(FMthi, 32'h0000_1234, 32'd0, 1'b0);
    chk("mthi_hi", 64'(hi), 64'h0000_0000_0000_1234);

    run_op(FDiv, 32'hffff_fff9, 32'd2, 1'b0);
`ifdef HILO_MULDIV_DIV_EN
    chk("div_neg_lo", 64'(lo), 64'h0000_0000_ffff_fffd);
    chk("div_neg_hi", 64'(hi), 64'h0000_0000_ffff_ffff);
`endif
    run_op(FDivu, 32'd100, 32'd0, 1'b0);
`ifdef HILO_MULDIV_DIV_EN
    chk("divu_zero_lo", 64'(lo), 64'h0000_0000_ffff_ffff);
    chk("divu_zero_hi", 64'(hi), 64'd100);
`endif
    run_op(FDiv, 32'h8000_0000, 32'hffff_ffff, 1'b0);
    run_op(FDiv, 32'hffff_fff0, 32'd0, 1'b0);
    run_op(6'b100000, 32'h5555_5555, 32'h3, 1'b0);
    run_op(FMult, 32'h8000_0000, 32'h8000_0000, 1'b1);

    // Flush ten cycles into a multiply: HI/LO keep their prior values, no done.
    run_op(FMthi, 32'd5, 32'd0, 1'b0);
    run_op(FMtlo, 32'd6, 32'd0, 1'b0);
    start = 1'b1;
    funct = FMultu;
    a     = 32'h1234_5678;
    b     = 32'h9abc_def0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    chk("flush_no_done", 64'(done), 64'd0);
    chk("flush_hi", 64'(hi), 64'd5);
    chk("flush_lo", 64'(lo), 64'd6);

    // Flush beats a same-cycle MT* request in IDLE.
    start = 1'b1;
    flush = 1'b1;
    funct = FMthi;
    a     = 32'h0000_0077;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("flush_mthi_hi", 64'(hi), 64'(exp_hi));
    chk("flush_mthi_busy", 64'(busy), 64'd0);

    // Reset in the middle of an operation.
    start = 1'b1;
    funct = FMult;
    a     = 32'h0000_1111;
    b     = 32'h0000_2222;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      run_op(ops[$urandom_range(7)], pick_operand(), pick_operand(),
             bit'($urandom_range(1)));
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
